// File: rtl/counter_rmw_ctrl.sv
// Read-modify-write controller for a RAM of 8-bit adaptive probability
// counters: init sweep, 1-cycle prediction, write-back with a one-deep bypass.
module counter_rmw_ctrl #(
  parameter int         NUM_COL    = 4,
  parameter int         ADDR_WIDTH = 12,
  parameter int         DATA_WIDTH = NUM_COL * 8,
  parameter int         LANE_W     = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  parameter int         RATE       = 4,
  parameter logic [7:0] INIT_VAL   = 8'd128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LANE_W-1:0]     req_lane,
  input  logic                  req_bit,
  output logic                  pred_valid,
  output logic [7:0]            pred,
  output logic                  init_done,
  output logic                  ram_ena,
  output logic [NUM_COL-1:0]    ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;

  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;
  logic [LANE_W-1:0]     s1_lane_q;
  logic                  s1_bit_q;

  logic                  byp_valid_q;
  logic [ADDR_WIDTH-1:0] byp_addr_q;
  logic [LANE_W-1:0]     byp_lane_q;
  logic [7:0]            byp_data_q;

  logic [7:0]            ram_byte;
  logic [7:0]            old_b;
  logic [7:0]            new_b;
  logic                  byp_hit;
  logic                  accept;

  always_comb begin
    ram_byte = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      if (LANE_W'(i) == s1_lane_q) begin
        ram_byte = ram_dob[i*8 +: 8];
      end
    end
  end

  // A write issued last cycle raced this stage's read; take the written value.
  assign byp_hit = byp_valid_q
                 && (byp_addr_q == s1_addr_q)
                 && (byp_lane_q == s1_lane_q);

  assign old_b = byp_hit ? byp_data_q : ram_byte;

  always_comb begin
    new_b = old_b;
    if (s1_bit_q) begin
      new_b = old_b + ((8'd255 - old_b) >> RATE);
    end else begin
      new_b = old_b - (old_b >> RATE);
    end
  end

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    req_ready = 1'b0;
    ram_ena   = 1'b0;
    ram_wea   = '0;
    ram_addra = s1_addr_q;
    ram_dina  = {NUM_COL{new_b}};
    unique case (state_q)
      S_INIT: begin
        ram_ena   = 1'b1;
        ram_wea   = '1;
        ram_addra = sweep_q;
        ram_dina  = {NUM_COL{INIT_VAL}};
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        req_ready = 1'b1;
        if (s1_valid_q) begin
          ram_ena = 1'b1;
          ram_wea = NUM_COL'(1) << s1_lane_q;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
    // Reset wins over any write or stage still in flight this cycle.
    if (!rst_n) begin
      req_ready = 1'b0;
      ram_ena   = 1'b0;
      ram_wea   = '0;
    end
  end

  assign accept     = req_valid & req_ready;
  assign ram_enb    = accept;
  assign ram_addrb  = req_addr;
  assign pred_valid = s1_valid_q & rst_n;
  assign pred       = pred_valid ? old_b : 8'd0;
  assign init_done  = (state_q == S_RUN) & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_lane_q   <= '0;
      s1_bit_q    <= 1'b0;
      byp_valid_q <= 1'b0;
      byp_addr_q  <= '0;
      byp_lane_q  <= '0;
      byp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      s1_valid_q  <= accept;
      if (accept) begin
        s1_addr_q <= req_addr;
        s1_lane_q <= req_lane;
        s1_bit_q  <= req_bit;
      end
      byp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        byp_addr_q <= s1_addr_q;
        byp_lane_q <= s1_lane_q;
        byp_data_q <= new_b;
      end
    end
  end

endmodule

// File: doc/counter_rmw_ctrl.md
Name: counter_rmw_ctrl

Overview:
- Read-modify-write controller that sits directly in front of the byte-write true-dual-port RAM holding 8-bit adaptive probability counters.
- Accepts one (address, lane, bit) update per cycle and reads the word on RAM port B.
- Emits the old counter byte as a prediction, computes the adapted counter and writes it back through port A with a one-hot byte enable.
- Clears the whole RAM after reset with an init sweep before accepting traffic.

Parameters:
- NUM_COL, 4, byte lanes per RAM word.
- ADDR_WIDTH, 12, RAM address width.
- DATA_WIDTH, NUM_COL*8, RAM word width.
- LANE_W, clog2(NUM_COL), lane index width.
- RATE, 4, adaptation shift (1..7).
- INIT_VAL, 128, counter value written by the init sweep.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  update request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_addr  in  ADDR_WIDTH  counter word address.
- req_lane  in  LANE_W  byte lane within the word.
- req_bit  in  1  coded bit (1 = increase counter).
- pred_valid  out  1  prediction valid.
- pred  out  8  counter value before the update.
- init_done  out  1  high once the init sweep has completed.
- ram_ena  out  1  port A enable.
- ram_wea  out  NUM_COL  port A byte write enables.
- ram_addra  out  ADDR_WIDTH  port A address.
- ram_dina  out  DATA_WIDTH  port A write data.
- ram_enb  out  1  port B enable.
- ram_addrb  out  ADDR_WIDTH  port B address.
- ram_dob  in  DATA_WIDTH  port B read data, registered, valid 1 cycle after ram_enb.

Behaviour:
- One clock (clk), synchronous active-low reset (rst_n). All state updates on the rising edge; rst_n is sampled only at the edge.
- Reset values:
  - FSM = INIT, sweep counter = 0, s1_valid = 0, bypass_valid = 0.
  - pred_valid = 0, pred = 0, init_done = 0, req_ready = 0.
  - ram_ena/ram_enb/ram_wea = 0.
- FSM INIT:
  - Each cycle: ram_ena=1, ram_wea=all ones, ram_addra=sweep counter, ram_dina=INIT_VAL replicated in every lane. Counter increments.
  - After address 2^ADDR_WIDTH-1 is written, go to RUN. init_done=1 from the next cycle, so INIT lasts exactly 2^ADDR_WIDTH cycles.
  - req_ready=0 and ram_enb=0 throughout INIT.
- FSM RUN: req_ready=1 every cycle; no stalls and no downstream backpressure.
- S0 (acceptance cycle T), combinational:
  - ram_enb = req_valid & req_ready; ram_addrb = req_addr.
  - addr, lane and bit are registered into S1 with s1_valid=1.
- S1 (cycle T+1):
  - old = byte `lane` of ram_dob.
  - Bypass: if bypass_valid, bypass_addr==s1_addr and bypass_lane==s1_lane, then old = bypass_data instead.
  - pred = old; pred_valid = s1_valid, so latency is 1 cycle after acceptance.
- Update arithmetic, 8-bit unsigned, no overflow possible:
  - bit=1: new = old + ((255-old) >> RATE).
  - bit=0: new = old - (old >> RATE).
  - 255 with bit=1 stays 255; 0 with bit=0 stays 0.
- Write-back in the same S1 cycle:
  - ram_ena=1, ram_wea=onehot(lane), ram_addra=s1_addr, ram_dina=new replicated to all lanes.
  - Bypass register captures {addr, lane, new} with bypass_valid=1. It captures nothing in cycles with no S1, where bypass_valid goes to 0.
- Hazard rule:
  - A port-A write in cycle T and a port-B read of the same address in cycle T race. The one-deep bypass is therefore mandatory.
  - Writes from cycle T-1 or earlier are already in RAM and must not be bypassed.
- Different lane, same address, back-to-back: no bypass; the RAM read value is used.
- Reset asserted mid-operation: any pending S1 is discarded (no write, pred_valid=0). Return to INIT and re-sweep the whole RAM.
- ram_ena/ram_enb are 0 in RUN when the respective stage is empty.

Test Plan:
- Reset, ADDR_WIDTH=4 -> exactly 16 INIT writes (addr 0..15, wea=1111, dina=0x80808080); init_done=1 on cycle 17; req_ready=0 until RUN.
- Single req addr 3 lane 2 bit=1 -> pred_valid next cycle, pred=128; write wea=0100 addr 3, lane byte 135.
- Back-to-back addr 5 lane 0, bit=1 then bit=1 -> preds 128, 135 (bypass); written 135 then 142.
- Back-to-back addr 5 lane 0 bit=1, then addr 5 lane 1 bit=0 -> preds 128, 128; lane1 written 120; lane0 stays 135.
- Same addr/lane with one idle cycle between -> second pred 135 from RAM, bypass not used; bit=0 sequence from 0 stays 0, bit=1 from 255 stays 255.
- Reset pulsed while S1 valid -> no port-A write that cycle, pred_valid=0, full INIT sweep repeats; a later read of the previously updated counter returns 128.
